// File: rtl/bram_write_datapath.sv
// Write-side datapath for the BRAM accessor: turns an accepted valid/ready beat
// stream into consecutive BRAM writes from a captured base and reports progress.
module bram_write_datapath #(
  parameter int unsigned CNT_BIT = 31,
  parameter int unsigned DWIDTH  = 32,
  parameter int unsigned AWIDTH  = 17
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start_i,
  input  logic [CNT_BIT-1:0] run_count_i,
  input  logic [AWIDTH-1:0]  base_addr_i,
  input  logic               run_i,
  input  logic               s_valid_i,
  input  logic [DWIDTH-1:0]  s_data_i,
  output logic               s_ready_o,
  output logic [CNT_BIT-1:0] cnt_o,
  output logic [AWIDTH-1:0]  addr_o,
  output logic               ce_o,
  output logic               we_o,
  output logic [DWIDTH-1:0]  d_o,
  output logic               busy_o,
  output logic               done_o
);

  localparam logic [CNT_BIT-1:0] CNT_ONES = {CNT_BIT{1'b1}};
  localparam logic [CNT_BIT-1:0] CNT_ONE  = CNT_BIT'(1);

  logic [CNT_BIT-1:0] n_q, n_d;
  logic [AWIDTH-1:0]  base_q, base_d;
  logic [CNT_BIT-1:0] cnt_q, cnt_d;
  logic [AWIDTH-1:0]  addr_q, addr_d;
  logic [DWIDTH-1:0]  data_q, data_d;
  logic               wr_q, wr_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               last_c;
  logic               ready_c;
  logic               accept_c;
  logic [CNT_BIT-1:0] cnt_inc_c;

  // cnt starts at -1, so reaching N-1 means exactly N beats were accepted.
  assign last_c    = (cnt_q == (n_q - CNT_ONE));
  assign ready_c   = busy_q & run_i & ~last_c;
  assign accept_c  = s_valid_i & ready_c;
  assign cnt_inc_c = cnt_q + CNT_ONE;

  always_comb begin
    n_d    = n_q;
    base_d = base_q;
    cnt_d  = cnt_q;
    addr_d = addr_q;
    data_d = data_q;
    wr_d   = 1'b0;
    busy_d = busy_q;
    done_d = 1'b0;

    if (!busy_q) begin
      if (start_i) begin
        n_d    = run_count_i;
        base_d = base_addr_i;
        cnt_d  = CNT_ONES;
        busy_d = 1'b1;
      end
    end else if (last_c) begin
      busy_d = 1'b0;
      done_d = 1'b1;
    end else if (accept_c) begin
      cnt_d  = cnt_inc_c;
      addr_d = base_q + AWIDTH'(cnt_inc_c);
      data_d = s_data_i;
      wr_d   = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      n_q    <= '0;
      base_q <= '0;
      cnt_q  <= CNT_ONES;
      addr_q <= '0;
      data_q <= '0;
      wr_q   <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      n_q    <= n_d;
      base_q <= base_d;
      cnt_q  <= cnt_d;
      addr_q <= addr_d;
      data_q <= data_d;
      wr_q   <= wr_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign s_ready_o = ready_c;
  assign cnt_o     = cnt_q;
  assign addr_o    = addr_q;
  assign ce_o      = wr_q;
  assign we_o      = wr_q;
  assign d_o       = data_q;
  assign busy_o    = busy_q;
  assign done_o    = done_q;

endmodule

// File: tb/tb_bram_write_datapath.sv
// Randomized bench for bram_write_datapath against a transaction-level model
// that tracks the number of beats taken in the current run.
module tb_bram_write_datapath;

  localparam int unsigned CW = 31;
  localparam int unsigned DW = 32;
  localparam int unsigned AW = 17;

  logic          clk;
  logic          reset;
  logic          start_i;
  logic [CW-1:0] run_count_i;
  logic [AW-1:0] base_addr_i;
  logic          run_i;
  logic          s_valid_i;
  logic [DW-1:0] s_data_i;
  logic          s_ready_o;
  logic [CW-1:0] cnt_o;
  logic [AW-1:0] addr_o;
  logic          ce_o;
  logic          we_o;
  logic [DW-1:0] d_o;
  logic          busy_o;
  logic          done_o;

  bram_write_datapath #(.CNT_BIT(CW), .DWIDTH(DW), .AWIDTH(AW)) dut (
    .clk(clk), .reset(reset), .start_i(start_i), .run_count_i(run_count_i),
    .base_addr_i(base_addr_i), .run_i(run_i), .s_valid_i(s_valid_i),
    .s_data_i(s_data_i), .s_ready_o(s_ready_o), .cnt_o(cnt_o), .addr_o(addr_o),
    .ce_o(ce_o), .we_o(we_o), .d_o(d_o), .busy_o(busy_o), .done_o(done_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_vec  = 0;
  int unsigned n_miss = 0;

  // Model: beats taken so far (k), run length, base, last write on the port.
  logic          m_busy;
  logic [CW-1:0] m_n;
  logic [AW-1:0] m_base;
  logic [CW-1:0] m_k;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_d;
  logic          m_write;
  logic          m_done;
  int unsigned   writes_seen;
  int unsigned   dones_seen;

  logic [CW-1:0] next_n;
  logic [AW-1:0] next_base;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 1'b0; m_n = '0; m_base = '0; m_k = '0;
    m_addr = '0; m_d = '0; m_write = 1'b0; m_done = 1'b0;
  endtask

  task automatic check_outputs();
    check("ce",   64'(ce_o),   64'(m_write));
    check("we",   64'(we_o),   64'(m_write));
    check("done", 64'(done_o), 64'(m_done));
    check("busy", 64'(busy_o), 64'(m_busy));
    check("cnt",  64'(cnt_o),  64'(CW'(m_k - CW'(1))));
    check("addr", 64'(addr_o), 64'(m_addr));
    check("data", 64'(d_o),    64'(m_d));
  endtask

  // One clock: drive inputs, check ready, advance model, check registered outputs.
  task automatic step(input logic start, input logic run, input logic valid);
    logic [DW-1:0] data;
    logic          exp_ready;
    data        = $urandom;
    start_i     = start;
    run_i       = run;
    s_valid_i   = valid;
    s_data_i    = data;
    run_count_i = next_n;
    base_addr_i = next_base;
    exp_ready   = m_busy && run && (m_k != m_n);
    #2;
    check("ready", 64'(s_ready_o), 64'(exp_ready));
    @(posedge clk);
    #1;
    m_write = 1'b0;
    m_done  = 1'b0;
    if (!m_busy && start) begin
      m_busy = 1'b1; m_n = next_n; m_base = next_base; m_k = '0;
    end else if (m_busy && m_k == m_n) begin
      m_busy = 1'b0; m_done = 1'b1;
    end else if (exp_ready && valid) begin
      m_addr  = AW'(32'(m_base) + 32'(m_k));
      m_d     = data;
      m_k     = m_k + CW'(1);
      m_write = 1'b1;
    end
    if (ce_o) writes_seen++;
    if (done_o) dones_seen++;
    check_outputs();
  endtask

  // vmode: 0 always valid, 1 toggling, 2 random; rand_run pauses run_i now and then.
  task automatic run_one(input logic [CW-1:0] n, input logic [AW-1:0] base,
                         input int vmode, input bit rand_run, input int mid_start);
    int cyc;
    logic v;
    logic r;
    next_n = n;
    next_base = base;
    step(1'b1, 1'b1, 1'b1);
    cyc = 0;
    while (m_busy && cyc < 200) begin
      case (vmode)
        0:       v = 1'b1;
        1:       v = (cyc % 2 == 0);
        default: v = ($urandom_range(0, 3) != 0);
      endcase
      r = rand_run ? ($urandom_range(0, 4) != 0) : 1'b1;
      if (cyc == mid_start) begin
        next_n = CW'($urandom_range(0, 3));
        next_base = AW'($urandom);
      end
      step(cyc == mid_start, r, v);
      cyc++;
    end
    if (m_busy) check("timeout", 64'(1), 64'(0));
    for (int i = 0; i < 2; i++) step(1'b0, 1'b1, 1'b1);
  endtask

  initial begin
    int unsigned w0, d0;
    reset = 1'b1; start_i = 1'b0; run_count_i = '0; base_addr_i = '0;
    run_i = 1'b0; s_valid_i = 1'b0; s_data_i = '0;
    next_n = '0; next_base = '0; writes_seen = 0; dones_seen = 0;
    model_reset();
    #12;
    check_outputs();
    @(posedge clk); #1;
    reset = 1'b0;

    w0 = writes_seen; d0 = dones_seen;
    run_one(CW'(4), AW'(17'h10), 0, 1'b0, -1);
    check("t1_writes", 64'(writes_seen - w0), 64'(4));
    check("t1_dones",  64'(dones_seen - d0),  64'(1));

    w0 = writes_seen;
    run_one(CW'(4), AW'(17'h40), 1, 1'b0, -1);
    check("t2_writes", 64'(writes_seen - w0), 64'(4));
    check("t2_cnt",    64'(cnt_o), 64'(3));

    run_one(CW'(1), AW'(17'h123), 0, 1'b0, -1);
    check("t3_cnt1",   64'(cnt_o), 64'(0));
    w0 = writes_seen; d0 = dones_seen;
    run_one(CW'(0), AW'(17'h200), 0, 1'b0, -1);
    check("t3_writes0", 64'(writes_seen - w0), 64'(0));
    check("t3_dones0",  64'(dones_seen - d0),  64'(1));

    run_one(CW'(4), AW'(17'h1FFFE), 0, 1'b0, -1);
    check("t4_addr",   64'(addr_o), 64'(17'h00001));

    w0 = writes_seen;
    run_one(CW'(8), AW'(17'h300), 0, 1'b0, 2);
    check("t5_writes", 64'(writes_seen - w0), 64'(8));

    // Reset after two of five writes abandons the run.
    w0 = writes_seen; d0 = dones_seen;
    next_n = CW'(5); next_base = AW'(17'h500);
    step(1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b1);
    reset = 1'b1;
    #1;
    model_reset();
    check_outputs();
    @(posedge clk); #1;
    check_outputs();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b1);
    check("t6_writes", 64'(writes_seen - w0), 64'(2));
    check("t6_dones",  64'(dones_seen - d0),  64'(0));

    for (int t = 0; t < 30; t++) begin
      logic [AW-1:0] b;
      b = ($urandom_range(0, 3) == 0) ? AW'(17'h1FFFF - 17'($urandom_range(0, 3))) : AW'($urandom);
      run_one(CW'($urandom_range(0, 7)), b, 2, 1'b1,
              ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 5)) : -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
